// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: op encodings, state encodings,
// next-PC select codes and default widths/vectors.
// No logic; imported by pc_sequencer and pc_next_sel.
package pc_seq_pkg;

    localparam int           AW_DEF        = 12;
    localparam logic [11:0]  RESET_VEC_DEF = 12'h000;

    // Flow op encodings; 5-7 decode as NOP.
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    // FSM states.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_RWAIT = 1'b1;

    // Next-PC source select.
    localparam logic [2:0] SEL_HOLD = 3'd0;
    localparam logic [2:0] SEL_INC  = 3'd1;
    localparam logic [2:0] SEL_TGT  = 3'd2;
    localparam logic [2:0] SEL_BRZ  = 3'd3;
    localparam logic [2:0] SEL_STK  = 3'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: hold / pc+1 / target / zero-flag branch / stack return.
// Latency: purely combinational. Backpressure: none (decision made by caller).
// Ports: sel (source select), pc, target, stk0, zf in; pc_inc (pc+1 wrap), nxt out.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [2:0]    sel,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] stk0,
    input  logic          zf,
    output logic [AW-1:0] pc_inc,
    output logic [AW-1:0] nxt
);

    // Wraps modulo 2^AW by construction of the width.
    assign pc_inc = pc + AW'(1);

    always_comb begin
        nxt = pc;
        case (sel)
            SEL_INC:  nxt = pc_inc;
            SEL_TGT:  nxt = target;
            SEL_BRZ:  nxt = zf ? target : pc_inc;
            SEL_STK:  nxt = stk0;
            default:  nxt = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC and call/return sequencer feeding a small return-address stack.
// Latency: all outputs registered, one edge after op acceptance; RET costs RET_LAT+1 cycles.
// Backpressure: busy=1 during a RET wait; en/op ignored until busy drops.
// Ports: clk, rst (async active-high), en, op, target, zf, stk0 in;
//        pc, pcx, push, pop, depth, busy, err out.
// Build option: define STACK_GUARD_EN to squash overflow CALL / underflow RET into NOP.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          AW        = AW_DEF,
    parameter int          DEPTH     = 4,
    parameter int          RET_LAT   = 2,
    parameter logic [AW-1:0] RESET_VEC = RESET_VEC_DEF[AW-1:0],
    localparam int         DW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [AW-1:0] target,
    input  logic          zf,
    input  logic [AW-1:0] stk0,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pcx,
    output logic          push,
    output logic          pop,
    output logic [DW-1:0] depth,
    output logic          busy,
    output logic          err
);

    localparam int            CW        = 3;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          is_call;
    logic          is_ret;
    logic          ovf;
    logic          unf;
    logic          squash;
    logic          do_call;
    logic          do_ret;
    logic [2:0]    sel;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;

    assign accept  = (state == ST_RUN) && en;
    assign is_call = accept && (op == OP_CALL);
    assign is_ret  = accept && (op == OP_RET);
    assign ovf     = is_call && (depth == DEPTH_MAX);
    assign unf     = is_ret && (depth == '0);

`ifdef STACK_GUARD_EN
    assign squash = ovf || unf;
`else
    assign squash = 1'b0;
`endif

    assign do_call = is_call && !squash;
    assign do_ret  = is_ret && !squash;

    always_comb begin
        sel = SEL_HOLD;
        if (state == ST_RWAIT) begin
            sel = (cnt == CW'(1)) ? SEL_STK : SEL_HOLD;
        end else if (en) begin
            case (op)
                OP_JMP:  sel = SEL_TGT;
                OP_BRZ:  sel = SEL_BRZ;
                // A squashed CALL/RET degrades to NOP.
                OP_CALL: sel = squash ? SEL_INC : SEL_TGT;
                OP_RET:  sel = squash ? SEL_INC : SEL_HOLD;
                default: sel = SEL_INC;
            endcase
        end
    end

    pc_next_sel #(.AW(AW)) u_next (
        .sel    (sel),
        .pc     (pc),
        .target (target),
        .stk0   (stk0),
        .zf     (zf),
        .pc_inc (pc_inc),
        .nxt    (pc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_VEC;
            pcx   <= '0;
            push  <= 1'b0;
            pop   <= 1'b0;
            depth <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            pc   <= pc_nxt;
            push <= do_call;
            pop  <= do_ret;
            if (ovf || unf) err <= 1'b1;

            if (do_call) begin
                pcx <= pc_inc;
                // Unguarded overflow still pushes but the count saturates.
                if (depth != DEPTH_MAX) depth <= depth + DW'(1);
            end else if (do_ret) begin
                if (depth != '0) depth <= depth - DW'(1);
            end

            if (state == ST_RWAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            end else if (do_ret) begin
                state <= ST_RWAIT;
                busy  <= 1'b1;
                cnt   <= CW'(RET_LAT);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [11:0] target;
    logic        zf;
    logic [11:0] stk0;
    logic [11:0] pc;
    logic [11:0] pcx;
    logic        push;
    logic        pop;
    logic [2:0]  depth;
    logic        busy;
    logic        err;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.AW(12), .DEPTH(4), .RET_LAT(2), .RESET_VEC(12'h000)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .zf(zf),
        .stk0(stk0), .pc(pc), .pcx(pcx), .push(push), .pop(pop),
        .depth(depth), .busy(busy), .err(err)
    );

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [11:0] target;
        logic        zf;
        logic [11:0] pc;
        logic        push;
        logic        pop;
        logic [11:0] pcx;
        logic [2:0]  depth;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic e, input logic [2:0] o, input logic [11:0] t, input logic z);
        en = e; op = o; target = t; zf = z;
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ret_seq();
        drive(1'b1, OP_RET, 12'h000, 1'b0);
        step();
        drive(1'b1, OP_NOP, 12'h000, 1'b0);
        step();
        step();
    endtask

    initial begin
        // {en, op, target, zf, pc, push, pop, pcx, depth, busy, err}
        tbl[0]  = '{1'b1, OP_NOP,  12'h000, 1'b0, 12'h001, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, OP_NOP,  12'h000, 1'b0, 12'h002, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, OP_JMP,  12'h100, 1'b0, 12'h100, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, OP_BRZ,  12'h040, 1'b0, 12'h101, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, OP_BRZ,  12'h040, 1'b1, 12'h040, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, OP_JMP,  12'h300, 1'b0, 12'h040, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, OP_JMP,  12'h010, 1'b0, 12'h010, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, OP_CALL, 12'h200, 1'b0, 12'h200, 1'b1, 1'b0, 12'h011, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, OP_NOP,  12'h000, 1'b0, 12'h201, 1'b0, 1'b0, 12'h011, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, OP_RET,  12'h000, 1'b0, 12'h201, 1'b0, 1'b1, 12'h011, 3'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, OP_JMP,  12'h3AA, 1'b0, 12'h201, 1'b0, 1'b0, 12'h011, 3'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, OP_JMP,  12'h3AA, 1'b0, 12'h011, 1'b0, 1'b0, 12'h011, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, OP_NOP,  12'h000, 1'b0, 12'h012, 1'b0, 1'b0, 12'h011, 3'd0, 1'b0, 1'b0};

        stk0 = 12'h011;
        drive(1'b0, OP_NOP, 12'h000, 1'b0);
        rst = 1'b1;
        step();
        chk("rst_pc",    32'(pc),    32'h000);
        chk("rst_pcx",   32'(pcx),   32'h000);
        chk("rst_push",  32'(push),  32'd0);
        chk("rst_pop",   32'(pop),   32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].op, tbl[i].target, tbl[i].zf);
            step();
            chk($sformatf("v%0d_pc", i),    32'(pc),    32'(tbl[i].pc));
            chk($sformatf("v%0d_push", i),  32'(push),  32'(tbl[i].push));
            chk($sformatf("v%0d_pop", i),   32'(pop),   32'(tbl[i].pop));
            chk($sformatf("v%0d_pcx", i),   32'(pcx),   32'(tbl[i].pcx));
            chk($sformatf("v%0d_depth", i), 32'(depth), 32'(tbl[i].depth));
            chk($sformatf("v%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
            chk($sformatf("v%0d_err", i),   32'(err),   32'(tbl[i].err));
        end

        // Four CALLs fill the stack.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_CALL, 12'h400 + 12'(i * 16), 1'b0);
            step();
            chk($sformatf("call%0d_pc", i),    32'(pc),    32'(12'h400 + 12'(i * 16)));
            chk($sformatf("call%0d_push", i),  32'(push),  32'd1);
            chk($sformatf("call%0d_depth", i), 32'(depth), 32'(i + 1));
            chk($sformatf("call%0d_err", i),   32'(err),   32'd0);
        end
        // Fifth CALL overflows from pc=0x430.
        drive(1'b1, OP_CALL, 12'h440, 1'b0);
        step();
        chk("ovf_err",   32'(err),   32'd1);
        chk("ovf_depth", 32'(depth), 32'd4);
`ifdef STACK_GUARD_EN
        chk("ovf_pc",    32'(pc),    32'h431);
        chk("ovf_push",  32'(push),  32'd0);
`else
        chk("ovf_pc",    32'(pc),    32'h440);
        chk("ovf_push",  32'(push),  32'd1);
        chk("ovf_pcx",   32'(pcx),   32'h431);
`endif

        // Drain the stack; every return lands on stk0.
        for (int i = 0; i < 4; i++) ret_seq();
        chk("drain_depth", 32'(depth), 32'd0);
        chk("drain_pc",    32'(pc),    32'h011);
        chk("drain_err",   32'(err),   32'd1);

        // RET with empty stack.
        drive(1'b1, OP_RET, 12'h000, 1'b0);
        step();
        chk("unf_depth", 32'(depth), 32'd0);
        chk("unf_err",   32'(err),   32'd1);
`ifdef STACK_GUARD_EN
        chk("unf_pop",  32'(pop),  32'd0);
        chk("unf_busy", 32'(busy), 32'd0);
        chk("unf_pc",   32'(pc),   32'h012);
`else
        chk("unf_pop",  32'(pop),  32'd1);
        chk("unf_busy", 32'(busy), 32'd1);
        chk("unf_pc",   32'(pc),   32'h011);
        drive(1'b1, OP_NOP, 12'h000, 1'b0);
        step();
        step();
        chk("unf_done_busy", 32'(busy), 32'd0);
        chk("unf_done_pc",   32'(pc),   32'h011);
`endif

        // Async reset in the middle of a RET wait (cnt==1).
        drive(1'b1, OP_CALL, 12'h500, 1'b0);
        step();
        drive(1'b1, OP_RET, 12'h000, 1'b0);
        step();
        drive(1'b1, OP_NOP, 12'h000, 1'b0);
        step();
        chk("rwait_busy", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_pc",    32'(pc),    32'h000);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_depth", 32'(depth), 32'd0);
        chk("arst_err",   32'(err),   32'd0);
        #1;
        rst = 1'b0;
        drive(1'b1, OP_NOP, 12'h000, 1'b0);
        step();
        chk("post_rst_pc", 32'(pc), 32'h001);

        // pc+1 wrap and CALL return address at the top of the space.
        drive(1'b1, OP_JMP, 12'hFFF, 1'b0);
        step();
        drive(1'b1, OP_NOP, 12'h000, 1'b0);
        step();
        chk("wrap_pc", 32'(pc), 32'h000);
        drive(1'b1, OP_JMP, 12'hFFF, 1'b0);
        step();
        drive(1'b1, OP_CALL, 12'h123, 1'b0);
        step();
        chk("wrap_pcx",  32'(pcx),  32'h000);
        chk("wrap_push", 32'(push), 32'd1);
        chk("wrap_cpc",  32'(pc),   32'h123);
        drive(1'b0, OP_NOP, 12'h000, 1'b0);
        step();
        chk("wrap_push_end", 32'(push), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and call/return control stage that sits directly upstream of the 4-entry return-address stack.
- Owns the 12-bit PC and executes decoded flow ops: NOP, JMP, BRZ, CALL, RET.
- On CALL, drives the stack's write data (pcx) and push strobe. On RET, drives the pop strobe and reloads the PC from the stack's registered read output (stk0).
- Tracks stack depth locally to flag overflow and underflow.

Parameters:
- AW, 12, PC/address width; must equal the stack data width.
- DEPTH, 4, number of stack entries; full when depth==DEPTH.
- RET_LAT, 2, cycles from the edge where pop is sampled high by the stack to the edge where stk0 holds the popped address; legal range 1..7.
- RESET_VEC, 12'h000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  step enable; op is accepted only when en=1 and busy=0.
- op  in  3  flow op: 0 NOP, 1 JMP, 2 BRZ, 3 CALL, 4 RET; 5-7 are treated as NOP.
- target  in  AW  jump/branch/call destination.
- zf  in  1  zero flag used by BRZ.
- stk0  in  AW  return address from stack (registered read).
- pc  out  AW  current program counter.
- pcx  out  AW  return address presented to stack; valid while push=1.
- push  out  1  one-cycle stack write/increment strobe.
- pop  out  1  one-cycle stack decrement strobe.
- depth  out  clog2(DEPTH+1)  entries currently on stack.
- busy  out  1  RET in progress; new ops are ignored.
- err  out  1  sticky overflow/underflow flag; cleared only by rst.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, any state including mid-RET): pc=RESET_VEC, pcx=0, push=0, pop=0, depth=0, busy=0, err=0, state=RUN, wait counter=0.
- All outputs are registered. push/pop are single-cycle pulses, high in the cycle after the accepting edge.
- States: RUN and RWAIT.
- RUN, en=0: all state holds; push=pop=0.
- RUN, en=1, accepted op (all effects on the same edge):
  - NOP: pc<=pc+1.
  - JMP: pc<=target.
  - BRZ: pc<=zf ? target : pc+1.
  - CALL: pcx<=pc+1; push<=1; pc<=target; depth<=depth+1.
  - RET: pop<=1; depth<=depth-1; busy<=1; cnt<=RET_LAT; state<=RWAIT. pc holds.
- RWAIT:
  - op and en are ignored; cnt decrements every cycle regardless of en.
  - On the edge where cnt==1: pc<=stk0; busy<=0; state<=RUN.
  - Total RET cost is RET_LAT+1 cycles from acceptance to the next op acceptance.
- Arithmetic: pc+1 wraps modulo 2^AW (12'hFFF -> 12'h000). pcx for CALL at 12'hFFF is 12'h000.
- Overflow: CALL with depth==DEPTH. Underflow: RET with depth==0. Both set err<=1 (sticky); see Optional Feature for the rest.
- Only one op per cycle by encoding, so push and pop are never high together.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined: an overflow CALL or underflow RET is squashed and executes as NOP (pc<=pc+1, no push/pop, depth unchanged, no RWAIT); err is set.
- Undefined: the op executes normally (strobe issued, jump taken, RWAIT entered for RET). depth saturates at DEPTH or 0 instead of wrapping; err is set.

Decomposition:
- Package pc_seq_pkg holds:
  - op encodings OP_NOP..OP_RET.
  - AW default and RESET_VEC default.
  - state encoding ST_RUN/ST_RWAIT.
- One natural sub-module, pc_next_sel: combinational next-PC mux (pc+1 / target / zf select / stk0). The FSM, counter and depth tracking stay in the top module.

Test Plan (DEPTH=4, RET_LAT=2):
- Reset to pc=0. Sequence NOP, NOP, JMP target=0x100, BRZ zf=0, BRZ zf=1 target=0x040 -> pc 1, 2, 0x100, 0x101, 0x040. push/pop stay 0.
- At pc=0x010, CALL target=0x200 -> next cycle push=1, pcx=0x011, pc=0x200, depth=1. Push pulse lasts exactly one cycle.
- RET at depth=1, with the stack model returning 0x011 -> pop=1 for one cycle, busy=1 for 2 cycles, pc=0x011 on the 3rd edge. An op driven during busy is ignored.
- Five CALLs from depth 0 -> depth=4, err=1 on the fifth.
  - Guard on: fifth push absent, pc=old pc+1.
  - Guard off: fifth push present, depth stays 4.
- RET at depth=0 -> err=1.
  - Guard on: no pop, pc+1, busy stays 0.
  - Guard off: pop issued, depth stays 0.
- Assert rst during RWAIT (cnt=1) -> pc=0, busy=0, depth=0, err=0 immediately (async). After release, NOP gives pc=1. pc=0xFFF + NOP -> pc=0x000.
